// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, CPU fetch address and imem write port of the boot loader.
interface imem_loader_if;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [5:0]  cpu_a;
   logic [5:0]  imem_a;
   logic [31:0] imem_wd;
   logic        imem_we;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        err;
   modport master (output start, rx_data, rx_valid, cpu_a,
                   input rx_ready, imem_a, imem_wd, imem_we, cpu_reset, busy, done, err);
   modport slave (input start, rx_data, rx_valid, cpu_a,
                  output rx_ready, imem_a, imem_wd, imem_we, cpu_reset, busy, done, err);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into imem words while holding the CPU in reset, then hands imem to the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte before the CPU is released.
module imem_loader #(
   parameter int NWORDS = 32
) (
   input logic         clk,
   input logic         reset,
   imem_loader_if.slave bus
);
`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif
   state_t      state, nxt;
   logic [5:0]  wcnt;
   logic [1:0]  bcnt;
   logic [31:0] shreg;
   logic [7:0]  sum;
   logic        rx_ready, imem_we, cpu_reset, busy, done, err;
   logic        fire, last, start_ok, chk_n, err_n;
   assign fire     = bus.rx_valid & rx_ready;
   assign last     = wcnt == 6'(NWORDS - 1);
   assign start_ok = bus.start & ~busy;
   always_comb begin
      nxt = state;
      case (state)
         RECV:    nxt = fire && bcnt == 2'd3 ? WRITE : RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
         WRITE:   nxt = last ? CHECK : RECV;
         CHECK:   nxt = !fire ? CHECK : 8'(sum + bus.rx_data) == 8'd0 ? DONE : ERR;
`else
         WRITE:   nxt = last ? DONE : RECV;
`endif
         default: nxt = start_ok ? RECV : state;
      endcase
   end
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign chk_n = nxt == CHECK;
   assign err_n = nxt == ERR;
`else
   assign chk_n = 1'b0;
   assign err_n = 1'b0;
`endif
   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wcnt      <= '0;
         bcnt      <= '0;
         shreg     <= '0;
         sum       <= '0;
         rx_ready  <= 1'b0;
         imem_we   <= 1'b0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= nxt;
         rx_ready  <= nxt == RECV || chk_n;
         imem_we   <= nxt == WRITE;
         busy      <= nxt == RECV || nxt == WRITE || chk_n;
         done      <= nxt == DONE;
         cpu_reset <= nxt != DONE;
         err       <= err_n;
         if (start_ok) begin
            wcnt <= '0;
            bcnt <= '0;
            sum  <= '0;
         end
         if (state == RECV && fire) begin
            shreg <= {bus.rx_data, shreg[31:8]};
            bcnt  <= bcnt + 2'd1;
            sum   <= sum + bus.rx_data;
         end
         if (state == WRITE && !last) begin
            wcnt <= wcnt + 6'd1;
            bcnt <= '0;
         end
      end
   end
   assign bus.rx_ready  = rx_ready;
   assign bus.imem_we   = imem_we;
   assign bus.imem_a    = done ? bus.cpu_a : wcnt;
   assign bus.imem_wd   = shreg;
   assign bus.cpu_reset = cpu_reset;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.err       = err;
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and address arbiter for the single-cycle CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit words, and writes them through the instruction memory's write port while holding the CPU in reset. After the last word it releases the CPU and hands the memory address port to the CPU's fetch address. It sits between the host byte source (UART receiver or bench), the CPU core and imem.

## Interface
- NWORDS, 32, number of words per load; legal range 1..64.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts rx_data this cycle.
- cpu_a  in  6  CPU fetch word address.
- imem_a  out  6  imem word address.
- imem_wd  out  32  imem write data.
- imem_we  out  1  imem write enable.
- cpu_reset  out  1  holds the CPU core in reset.
- busy  out  1  a load is in progress (RECV, WRITE or CHECK).
- done  out  1  program loaded, CPU running.
- err  out  1  last load failed its checksum (only with the macro).

## Operation
- States: IDLE, RECV, WRITE, CHECK (macro only), DONE, ERR.
- Reset values:
  - state = IDLE; wcnt = 0; bcnt = 0; shift register = 0; sum = 0.
  - cpu_reset = 1; done = 0; busy = 0; err = 0; imem_we = 0; rx_ready = 0.
- IDLE/DONE/ERR + start=1 → RECV:
  - Clear wcnt, bcnt, sum and err.
  - Raise cpu_reset the same edge.
- RECV:
  - rx_ready = 1.
  - On each transfer (rx_valid & rx_ready), shift the byte in little-endian: byte k goes to bits [8k+7:8k]. Increment bcnt (2 bits).
  - Add the byte to sum (8-bit, mod 256).
  - The transfer that completes bcnt = 3 moves to WRITE.
- WRITE (exactly 1 cycle):
  - imem_we = 1, imem_a = wcnt, imem_wd = assembled word; rx_ready = 0.
  - Next edge: if wcnt = NWORDS-1, go to CHECK (macro) or DONE. Otherwise increment wcnt, clear bcnt and return to RECV.
- DONE:
  - cpu_reset = 0, done = 1.
  - imem_a = cpu_a; imem_we = 0.
- imem_a outside DONE = wcnt.
- imem_wd outside WRITE = the shift register (don't-care).
- start while busy is ignored.
- rx_valid outside RECV/CHECK is ignored; no byte is consumed.
- Reset asserted mid-load returns to IDLE immediately with the reset values above. Partially written imem contents are left as-is.

## Timing
- rx_ready, imem_we, imem_a, cpu_reset, busy and done are decoded combinationally from the registered state only; there is no combinational path from rx_valid.
- A word needs at least 5 cycles: 4 transfers plus 1 WRITE.
- A full load of NWORDS words needs at least 5·NWORDS cycles after the start edge, plus 1 cycle in CHECK when the macro is enabled.
- cpu_reset deasserts on the cycle after the final WRITE (no macro) or after the checksum byte is accepted (macro).
- Back-to-back rx_valid is accepted at 1 byte/cycle in RECV. Bytes arriving during WRITE are stalled, not dropped.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, enter CHECK with rx_ready = 1 and accept one more byte c.
  - If (sum + c) mod 256 = 0, go to DONE.
  - Otherwise go to ERR: err = 1, cpu_reset = 1, done = 0. ERR is left only by start or reset.
- Not defined:
  - The CHECK and ERR states do not exist; err is tied to 0.
  - The last WRITE goes directly to DONE.

## Test plan
- Reset, then start, then 32 words 0x00000000..0x0000001F sent as bytes with rx_valid held high:
  - 32 imem_we pulses, imem_a = 0..31, imem_wd = the word index.
  - cpu_reset = 1 until after the last WRITE, then done = 1, cpu_reset = 0.
  - Cycle count = 160 from start (no macro).
- Bytes 0x78, 0x56, 0x34, 0x12 → imem_wd = 0x12345678 at imem_a = 0.
  - Inject rx_valid = 1 during the WRITE cycle: rx_ready = 0 and the byte is held, not lost.
- In DONE, drive cpu_a = 0x2A → imem_a = 0x2A, imem_we = 0.
  - Pulse start → cpu_reset = 1 next cycle and imem_a = 0.
- Assert reset after 10 words:
  - state IDLE, cpu_reset = 1, done = 0, wcnt = 0.
  - A fresh start reloads from imem_a = 0.
- Macro on, NWORDS = 1, word 0x01020304 (sum 0x0A):
  - Checksum 0xF6 → done = 1.
  - Checksum 0xF5 → err = 1, cpu_reset = 1; a later start clears err.
- start pulsed while busy → no effect on wcnt, bcnt or imem writes.
